// File: rtl/shift_sequencer.sv
// Step-pulse and direction controller for a rotating shift register; o_enable is registered one clock after the prescaler wraps, i_run pauses it.
// Defining SEQ_STEP_COUNT_EN adds o_steps, an 8-bit wrapping count of issued step pulses.
module shift_sequencer #(
    parameter int NB_COUNTER = 32,
    parameter int NB_SHIFT   = 4,
    parameter int LIMIT_R0   = 2**20,
    parameter int LIMIT_R1   = 2**22,
    parameter int LIMIT_R2   = 2**24,
    parameter int LIMIT_R3   = 2**26
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_run,
    input  logic [1:0]          i_rate,
    input  logic [1:0]          i_mode,
    input  logic [NB_SHIFT-1:0] i_shift,
    output logic                o_enable,
    output logic                o_selector
`ifdef SEQ_STEP_COUNT_EN
    ,
    output logic [7:0]          o_steps
`endif
);

    localparam logic [1:0] MODE_LEFT     = 2'b00;
    localparam logic [1:0] MODE_RIGHT    = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;
    localparam logic [1:0] MODE_HOLD     = 2'b11;

    typedef enum logic {
        ST_DOWN = 1'b0,
        ST_UP   = 1'b1
    } dir_t;

    logic [NB_COUNTER-1:0] counter;
    logic [NB_COUNTER-1:0] counter_next;
    logic [NB_COUNTER-1:0] limit_m1;
    logic                  tick;
    logic                  sel_next;
    logic                  was_pingpong;
    dir_t                  state_q;
    dir_t                  state_next;
    dir_t                  state_cur;

    always_comb begin
        case (i_rate)
            2'd0:    limit_m1 = NB_COUNTER'(LIMIT_R0 - 1);
            2'd1:    limit_m1 = NB_COUNTER'(LIMIT_R1 - 1);
            2'd2:    limit_m1 = NB_COUNTER'(LIMIT_R2 - 1);
            default: limit_m1 = NB_COUNTER'(LIMIT_R3 - 1);
        endcase
    end

    // >= rather than == so switching to a shorter period never overshoots.
    assign tick = i_run && (counter >= limit_m1);

    always_comb begin
        counter_next = counter;
        if (tick) begin
            counter_next = '0;
        end else if (i_run) begin
            counter_next = counter + NB_COUNTER'(1);
        end
    end

    // Direction decisions use o_enable, the edge on which the register actually shifts,
    // so the selector is already right for the following step.
    always_comb begin
        state_next = state_q;
        state_cur  = state_q;
        sel_next   = o_selector;
        case (i_mode)
            MODE_LEFT:  sel_next = 1'b1;
            MODE_RIGHT: sel_next = 1'b0;
            MODE_PINGPONG: begin
                if (!was_pingpong) begin
                    state_cur = o_selector ? ST_UP : ST_DOWN;
                end
                state_next = state_cur;
                if (state_cur == ST_UP) begin
                    if (i_shift[NB_SHIFT-1] || (o_enable && i_shift[NB_SHIFT-2])) begin
                        state_next = ST_DOWN;
                    end
                end else begin
                    if (i_shift[0] || (o_enable && i_shift[1])) begin
                        state_next = ST_UP;
                    end
                end
                sel_next = (state_next == ST_UP);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            counter      <= '0;
            o_enable     <= 1'b0;
            o_selector   <= 1'b1;
            state_q      <= ST_UP;
            was_pingpong <= 1'b0;
        end else begin
            counter      <= counter_next;
            o_enable     <= tick && (i_mode != MODE_HOLD);
            o_selector   <= sel_next;
            state_q      <= state_next;
            was_pingpong <= (i_mode == MODE_PINGPONG);
        end
    end

`ifdef SEQ_STEP_COUNT_EN
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            o_steps <= 8'd0;
        end else if (o_enable) begin
            o_steps <= o_steps + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed scenarios plus randomized run against a reference model.
module tb_shift_sequencer;

    logic       clock = 1'b0;
    logic       i_reset;
    logic       i_run;
    logic [1:0] i_rate;
    logic [1:0] i_mode;
    logic [3:0] shift_drv;
    logic [3:0] shift_in;
    logic [3:0] ring;
    logic       ring_load;
    logic       use_ring;
    logic       o_enable;
    logic       o_selector;
`ifdef SEQ_STEP_COUNT_EN
    logic [7:0] o_steps;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    shift_sequencer #(
        .NB_COUNTER(32),
        .NB_SHIFT  (4),
        .LIMIT_R0  (4),
        .LIMIT_R1  (8),
        .LIMIT_R2  (16),
        .LIMIT_R3  (32)
    ) dut (
        .clock     (clock),
        .i_reset   (i_reset),
        .i_run     (i_run),
        .i_rate    (i_rate),
        .i_mode    (i_mode),
        .i_shift   (shift_in),
        .o_enable  (o_enable),
        .o_selector(o_selector)
`ifdef SEQ_STEP_COUNT_EN
        ,
        .o_steps   (o_steps)
`endif
    );

    // Stand-in for the controlled rotating shift register.
    always @(posedge clock) begin
        if (ring_load) begin
            ring <= 4'b0001;
        end else if (o_enable) begin
            ring <= o_selector ? {ring[2:0], ring[3]} : {ring[0], ring[3:1]};
        end
    end

    assign shift_in = use_ring ? ring : shift_drv;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        repeat (2) cyc();
        i_reset = 1'b1;
    endtask

    function automatic int bounce_pos(input int k);
        int p;
        p = k % 6;
        return (p <= 3) ? p : 6 - p;
    endfunction

    task automatic test_reset();
        i_run = 1'b1; i_rate = 2'd0; i_mode = 2'b01;
        #2 i_reset = 1'b0;
        #1;
        checks++;
        if (o_enable !== 1'b0) begin
            failures++; $display("FAIL reset_enable: got %b expected 0", o_enable);
        end
        checks++;
        if (o_selector !== 1'b1) begin
            failures++; $display("FAIL reset_selector: got %b expected 1", o_selector);
        end
        repeat (3) cyc();
        checks++;
        if (o_enable !== 1'b0 || o_selector !== 1'b1) begin
            failures++; $display("FAIL reset_held: got en=%b sel=%b expected en=0 sel=1", o_enable, o_selector);
        end
`ifdef SEQ_STEP_COUNT_EN
        checks++;
        if (o_steps !== 8'd0) begin
            failures++; $display("FAIL reset_steps: got %0d expected 0", o_steps);
        end
`endif
    endtask

    task automatic test_left();
        i_run = 1'b1; i_rate = 2'd0; i_mode = 2'b00;
        do_reset();
        for (int k = 1; k <= 24; k++) begin
            cyc();
            checks++;
            if (o_enable !== (k % 4 == 0) || o_selector !== 1'b1) begin
                failures++;
                $display("FAIL left_cycle%0d: got en=%b sel=%b expected en=%b sel=1", k, o_enable, o_selector, (k % 4 == 0));
            end
        end
    endtask

    task automatic test_right();
        int pulses = 0;
        int last   = 0;
        i_run = 1'b1; i_rate = 2'd1; i_mode = 2'b01;
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            cyc();
            checks++;
            if (o_selector !== 1'b0) begin
                failures++; $display("FAIL right_sel_cycle%0d: got %b expected 0", k, o_selector);
            end
            if (o_enable === 1'b1) begin
                pulses++;
                checks++;
                if (k - last != 8) begin
                    failures++; $display("FAIL right_spacing: got %0d expected 8", k - last);
                end
                last = k;
            end
        end
        checks++;
        if (pulses != 5) begin
            failures++; $display("FAIL right_pulses: got %0d expected 5", pulses);
        end
        cyc();
`ifdef SEQ_STEP_COUNT_EN
        checks++;
        if (o_steps !== 8'd5) begin
            failures++; $display("FAIL right_steps: got %0d expected 5", o_steps);
        end
`endif
    endtask

    task automatic test_pingpong();
        logic       got;
        logic [3:0] exp_ring;
        i_run = 1'b1; i_rate = 2'd0; i_mode = 2'b10;
        use_ring  = 1'b1;
        ring_load = 1'b1;
        do_reset();
        ring_load = 1'b0;
        checks++;
        if (ring !== 4'b0001) begin
            failures++; $display("FAIL pingpong_start: got %b expected 0001", ring);
        end
        for (int k = 1; k <= 8; k++) begin
            got = 1'b0;
            for (int w = 0; w < 10 && !got; w++) begin
                cyc();
                got = o_enable;
            end
            checks++;
            if (!got) begin
                failures++; $display("FAIL pingpong_timeout_pulse%0d: got no pulse expected one within 10 clocks", k);
            end
            cyc();
            exp_ring = 4'b0001 << bounce_pos(k);
            checks++;
            if (ring !== exp_ring) begin
                failures++; $display("FAIL pingpong_step%0d: got %b expected %b", k, ring, exp_ring);
            end
        end
        use_ring = 1'b0;
    endtask

    task automatic test_rate_change();
        i_run = 1'b1; i_rate = 2'd3; i_mode = 2'b00;
        do_reset();
        repeat (20) cyc();
        i_rate = 2'd0;
        cyc();
        checks++;
        if (o_enable !== 1'b1) begin
            failures++; $display("FAIL rate_change_immediate: got %b expected 1", o_enable);
        end
        for (int k = 1; k <= 8; k++) begin
            cyc();
            checks++;
            if (o_enable !== (k % 4 == 0)) begin
                failures++; $display("FAIL rate_change_cycle%0d: got %b expected %b", k, o_enable, (k % 4 == 0));
            end
        end
    endtask

    task automatic test_pause_hold();
        i_run = 1'b1; i_rate = 2'd0; i_mode = 2'b00;
        do_reset();
        repeat (2) cyc();
        i_run = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            checks++;
            if (o_enable !== 1'b0) begin
                failures++; $display("FAIL pause_cycle%0d: got %b expected 0", k, o_enable);
            end
        end
        i_run = 1'b1;
        cyc();
        checks++;
        if (o_enable !== 1'b0) begin
            failures++; $display("FAIL resume_early: got %b expected 0", o_enable);
        end
        cyc();
        checks++;
        if (o_enable !== 1'b1) begin
            failures++; $display("FAIL resume_pulse: got %b expected 1", o_enable);
        end
        i_mode = 2'b01;
        cyc();
        i_mode = 2'b11;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            checks++;
            if (o_enable !== 1'b0 || o_selector !== 1'b0) begin
                failures++; $display("FAIL hold_cycle%0d: got en=%b sel=%b expected en=0 sel=0", k, o_enable, o_selector);
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        logic got = 1'b0;
        i_run = 1'b1; i_rate = 2'd0; i_mode = 2'b01;
        do_reset();
        for (int w = 0; w < 10 && !got; w++) begin
            cyc();
            got = o_enable;
        end
        checks++;
        if (!got) begin
            failures++; $display("FAIL midreset_timeout: got no pulse expected one within 10 clocks");
        end
        i_reset = 1'b0;
        #1;
        checks++;
        if (o_enable !== 1'b0 || o_selector !== 1'b1) begin
            failures++; $display("FAIL midreset_immediate: got en=%b sel=%b expected en=0 sel=1", o_enable, o_selector);
        end
        #2 i_reset = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            checks++;
            if (o_enable !== (k == 4)) begin
                failures++; $display("FAIL midreset_period_cycle%0d: got %b expected %b", k, o_enable, (k == 4));
            end
        end
    endtask

    task automatic test_random();
        int   m_cnt, lim;
        logic m_en, m_sel, m_up, m_pp, m_tick, cur_up;
        logic n_en, n_sel;
`ifdef SEQ_STEP_COUNT_EN
        int   m_steps = 0;
`endif
        i_run = 1'b1; i_rate = 2'd0; i_mode = 2'b10;
        do_reset();
        m_cnt = 0; m_en = 1'b0; m_sel = 1'b1; m_up = 1'b1; m_pp = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(15) == 0) i_mode = 2'($urandom_range(3));
            if ($urandom_range(31) == 0) i_rate = 2'($urandom_range(3));
            i_run = ($urandom_range(9) != 0);
            if ($urandom_range(1) == 0) shift_drv = 4'b0001 << $urandom_range(3);
            else                        shift_drv = 4'($urandom);
            lim    = 4 << i_rate;
            m_tick = i_run && (m_cnt >= lim - 1);
            n_en   = m_tick && (i_mode != 2'b11);
            n_sel  = m_sel;
            if (i_mode == 2'b00) n_sel = 1'b1;
            if (i_mode == 2'b01) n_sel = 1'b0;
            if (i_mode == 2'b10) begin
                cur_up = m_pp ? m_up : m_sel;
                if (cur_up && (shift_drv[3] || (m_en && shift_drv[2])))        cur_up = 1'b0;
                else if (!cur_up && (shift_drv[0] || (m_en && shift_drv[1]))) cur_up = 1'b1;
                m_up  = cur_up;
                n_sel = cur_up;
            end
            if (m_tick)     m_cnt = 0;
            else if (i_run) m_cnt = m_cnt + 1;
`ifdef SEQ_STEP_COUNT_EN
            if (m_en) m_steps = (m_steps + 1) % 256;
`endif
            m_pp  = (i_mode == 2'b10);
            m_en  = n_en;
            m_sel = n_sel;
            cyc();
            checks++;
            if (o_enable !== m_en || o_selector !== m_sel) begin
                failures++;
                $display("FAIL random_cycle%0d: got en=%b sel=%b expected en=%b sel=%b", n, o_enable, o_selector, m_en, m_sel);
            end
`ifdef SEQ_STEP_COUNT_EN
            checks++;
            if (o_steps !== 8'(m_steps)) begin
                failures++; $display("FAIL random_steps%0d: got %0d expected %0d", n, o_steps, m_steps);
            end
`endif
        end
    endtask

    initial begin
        i_reset   = 1'b1;
        i_run     = 1'b0;
        i_rate    = 2'd0;
        i_mode    = 2'b00;
        shift_drv = 4'b0001;
        ring_load = 1'b0;
        use_ring  = 1'b0;
        test_reset();
        test_left();
        test_right();
        test_pingpong();
        test_rate_change();
        test_pause_hold();
        test_reset_mid_pulse();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within 500000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
